sdc_supervisor: RTL and testbench

Parametrised shutdown-circuit (SDC) close/open supervisor for the EBS logic, replacing the single-watchdog SDC control block. It drives the SDC relay from either the cockpit (manual) or external (autonomous) activation path. It monitors N independent heartbeat watchdogs and verifies closure via the SDC sense line. Every abnormal opening is latched as a coded fault until it is explicitly cleared.

---
 rtl/sdc_supervisor.sv | 175 +++++++++++++++++
 tb/tb_sdc_supervisor.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_supervisor.sv
// sdc_supervisor: SDC relay close/open supervisor with N heartbeat watchdogs,
// debounced activation buttons, close verification and latched fault codes.
module sdc_supervisor #(
  parameter int unsigned N_WD          = 2,
  parameter int unsigned WD_TIMEOUT    = 1000,
  parameter int unsigned DEBOUNCE      = 50,
  parameter int unsigned CLOSE_TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            Power_on_Reset_n,
  input  logic            AS_driving_mode,
  input  logic            AS_close_SDC,
  input  logic            TS_Activation_Button_cockpit,
  input  logic            TS_Activation_Button_external,
  input  logic [N_WD-1:0] Watchdog,
  input  logic            Shutdown_circuit,
  input  logic            Fault_clear,
  output logic            To_SDC_relais,
  output logic            SDC_is_Ready,
  output logic [2:0]      Fault_code,
  output logic [N_WD-1:0] Wd_fault_mask
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam int unsigned WD_W  = $clog2(WD_TIMEOUT + 1);
  localparam int unsigned CL_W  = $clog2(CLOSE_TIMEOUT + 1);
  localparam int unsigned SYN_W = N_WD + 6;
  localparam int unsigned BTN_E = 0;
  localparam int unsigned BTN_C = 1;

  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_WD    = 3'd1;
  localparam logic [2:0] FC_CLOSE = 3'd2;
  localparam logic [2:0] FC_EXT   = 3'd3;
  localparam logic [2:0] FC_AS    = 3'd4;

  typedef enum logic [1:0] {S_OPEN, S_CLOSING, S_CLOSED, S_TRIPPED} state_t;

  logic [SYN_W-1:0] sync1, sync2;
  logic [1:0]       sync_vld;
  logic [N_WD-1:0]  wd_s, wd_q, wd_tog, wd_armed, wd_exp;
  logic [WD_W-1:0]  wd_cnt [N_WD];
  logic             mode_s, as_s, sense_s, clear_s, wd_ok;
  logic [1:0]       btn_s, btn_deb, btn_deb_q, btn_armed, btn_evt;
  logic [DB_W-1:0]  db_cnt [2];
  state_t           state;
  logic [CL_W-1:0]  cl_cnt;
  logic             closed_mode;

  assign wd_s    = sync2[SYN_W-1:6];
  assign mode_s  = sync2[5];
  assign as_s    = sync2[4];
  assign btn_s   = sync2[3:2];
  assign sense_s = sync2[1];
  assign clear_s = sync2[0];

  // Two-flop synchronisers; sync_vld marks when sync2 carries real samples.
  always_ff @(posedge clk or negedge Power_on_Reset_n) begin
    if (!Power_on_Reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
    end else begin
      sync1    <= {Watchdog, AS_driving_mode, AS_close_SDC,
                   TS_Activation_Button_cockpit, TS_Activation_Button_external,
                   Shutdown_circuit, Fault_clear};
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // Debounced levels, watchdog expiry and the combined watchdog health.
  always_comb begin
    btn_deb = '0;
    wd_exp  = '0;
    for (int i = 0; i < 2; i++) btn_deb[i] = (db_cnt[i] == DB_W'(DEBOUNCE));
    for (int i = 0; i < N_WD; i++) wd_exp[i] = wd_armed[i] && (wd_cnt[i] == WD_W'(WD_TIMEOUT));
  end

  // A button only produces events after it has been seen released once, so a
  // button held through reset cannot close the relay.
  assign btn_evt = btn_deb & ~btn_deb_q & btn_armed;
  assign wd_tog  = wd_s ^ wd_q;
  assign wd_ok   = (&wd_armed) && !(|wd_exp);

  // Debounce and watchdog counters.
  always_ff @(posedge clk or negedge Power_on_Reset_n) begin
    if (!Power_on_Reset_n) begin
      btn_deb_q <= '0;
      btn_armed <= '0;
      wd_q      <= '0;
      wd_armed  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      for (int i = 0; i < N_WD; i++) wd_cnt[i] <= '0;
    end else begin
      btn_deb_q <= btn_deb;
      btn_armed <= btn_armed | ({2{sync_vld[1]}} & ~btn_s);
      wd_q      <= wd_s;
      wd_armed  <= wd_armed | wd_tog;
      for (int i = 0; i < 2; i++) begin
        if (!btn_s[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_W'(DEBOUNCE)) db_cnt[i] <= db_cnt[i] + DB_W'(1);
      end
      for (int i = 0; i < N_WD; i++) begin
        if (wd_tog[i]) wd_cnt[i] <= '0;
        else if (wd_cnt[i] != WD_W'(WD_TIMEOUT)) wd_cnt[i] <= wd_cnt[i] + WD_W'(1);
      end
    end
  end

  // Supervisor FSM with registered relay, ready and latched fault outputs.
  always_ff @(posedge clk or negedge Power_on_Reset_n) begin
    if (!Power_on_Reset_n) begin
      state         <= S_OPEN;
      cl_cnt        <= '0;
      closed_mode   <= 1'b0;
      To_SDC_relais <= 1'b0;
      SDC_is_Ready  <= 1'b0;
      Fault_code    <= FC_NONE;
      Wd_fault_mask <= '0;
    end else begin
      To_SDC_relais <= (state == S_CLOSING) || (state == S_CLOSED);
      SDC_is_Ready  <= (state == S_OPEN) && wd_ok;
      case (state)
        S_OPEN: begin
          cl_cnt <= '0;
          if (wd_ok && ((!mode_s && btn_evt[BTN_C]) ||
                        (mode_s && btn_evt[BTN_E] && as_s))) begin
            state       <= S_CLOSING;
            closed_mode <= mode_s;
          end
        end
        S_CLOSING: begin
          cl_cnt <= cl_cnt + CL_W'(1);
          if (!wd_ok) begin
            state         <= S_TRIPPED;
            Fault_code    <= FC_WD;
            Wd_fault_mask <= wd_exp;
          end else if (sense_s) begin
            state <= S_CLOSED;
          end else if (cl_cnt == CL_W'(CLOSE_TIMEOUT - 1)) begin
            // Counter would reach CLOSE_TIMEOUT on this edge without sense.
            state         <= S_TRIPPED;
            Fault_code    <= FC_CLOSE;
            Wd_fault_mask <= '0;
          end
        end
        S_CLOSED: begin
          if (!wd_ok) begin
            state         <= S_TRIPPED;
            Fault_code    <= FC_WD;
            Wd_fault_mask <= wd_exp;
          end else if (!sense_s) begin
            state         <= S_TRIPPED;
            Fault_code    <= FC_EXT;
            Wd_fault_mask <= '0;
          end else if (closed_mode && !as_s) begin
            state         <= S_TRIPPED;
            Fault_code    <= FC_AS;
            Wd_fault_mask <= '0;
          end
        end
        S_TRIPPED: begin
          if (clear_s && wd_ok && (btn_deb == 2'b00)) begin
            state         <= S_OPEN;
            Fault_code    <= FC_NONE;
            Wd_fault_mask <= '0;
          end
        end
        default: state <= S_OPEN;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_supervisor.sv
// tb_sdc_supervisor: self-checking bench for sdc_supervisor.
module tb_sdc_supervisor;

  localparam int N_WD = 2;
  localparam int WT   = 16;
  localparam int DB   = 4;
  localparam int CT   = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mode = 1'b0;
  logic            as_close = 1'b0;
  logic            btn_c = 1'b0;
  logic            btn_e = 1'b0;
  logic            sense = 1'b0;
  logic            fclr = 1'b0;
  logic [N_WD-1:0] wd = '0;
  logic            relay, ready;
  logic [2:0]      code;
  logic [N_WD-1:0] mask;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int period [N_WD];
  int next_tog [N_WD];
  int last_tog [N_WD];

  typedef struct packed {
    logic m;
    logic as_c;
    logic ext;
    logic exp_close;
  } vec_t;
  vec_t vecs [6];

  sdc_supervisor #(
    .N_WD(N_WD), .WD_TIMEOUT(WT), .DEBOUNCE(DB), .CLOSE_TIMEOUT(CT)
  ) dut (
    .clk                           (clk),
    .Power_on_Reset_n              (rst_n),
    .AS_driving_mode               (mode),
    .AS_close_SDC                  (as_close),
    .TS_Activation_Button_cockpit  (btn_c),
    .TS_Activation_Button_external (btn_e),
    .Watchdog                      (wd),
    .Shutdown_circuit              (sense),
    .Fault_clear                   (fclr),
    .To_SDC_relais                 (relay),
    .SDC_is_Ready                  (ready),
    .Fault_code                    (code),
    .Wd_fault_mask                 (mask)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Heartbeat generator: channel i toggles every period[i] cycles (0 = stopped),
  // driven 2 time units after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N_WD; i++) begin
        if (period[i] != 0 && cyc >= next_tog[i]) begin
          wd[i] = ~wd[i];
          last_tog[i] = cyc;
          next_tog[i] = cyc + period[i];
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got cyc=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns number of cycles until relay==val, or -1 if the limit expires.
  task automatic wait_relay(input logic val, input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      if (relay === val) begin
        n = i;
        break;
      end
      tick(1);
    end
  endtask

  task automatic close_loop(input logic m);
    int n;
    mode = m;
    as_close = m;
    sense = 1'b0;
    tick(6);
    if (m) btn_e = 1'b1;
    else   btn_c = 1'b1;
    wait_relay(1'b1, 30, n);
    check("close_relay_up", 32'(n >= 0), 32'(1));
    sense = 1'b1;
    tick(6);
    btn_c = 1'b0;
    btn_e = 1'b0;
    check("close_relay_held", 32'(relay), 32'(1));
    check("close_code", 32'(code), 32'(0));
  endtask

  task automatic do_clear();
    sense = 1'b0;
    fclr = 1'b1;
    tick(6);
    fclr = 1'b0;
    tick(3);
    check("clear_code", 32'(code), 32'(0));
    check("clear_mask", 32'(mask), 32'(0));
    check("clear_ready", 32'(ready), 32'(1));
  endtask

  task automatic restart_wd(input int c);
    period[c] = 5;
    next_tog[c] = cyc + 1;
  endtask

  initial begin
    int   n, l, drop, cnt, lat, c, p;
    logic seen, m, exp_trip;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < N_WD; i++) begin
      period[i] = 5;
      next_tog[i] = 3 + 2 * i;
      last_tog[i] = 0;
    end

    // Reset values
    tick(2);
    check("rst_relay", 32'(relay), 32'(0));
    check("rst_ready", 32'(ready), 32'(0));
    check("rst_code", 32'(code), 32'(0));
    check("rst_mask", 32'(mask), 32'(0));
    tick(1);
    rst_n = 1'b1;
    tick(20);

    // Manual close with exact button-to-relay latency, then sense loss
    check("ready_before_press", 32'(ready), 32'(1));
    btn_c = 1'b1;
    tick(7);
    check("btn_latency_early", 32'(relay), 32'(0));
    tick(1);
    check("btn_latency", 32'(relay), 32'(1));
    sense = 1'b1;
    tick(2);
    btn_c = 1'b0;
    tick(4);
    check("closed_relay", 32'(relay), 32'(1));
    check("closed_code", 32'(code), 32'(0));
    check("closed_not_ready", 32'(ready), 32'(0));
    sense = 1'b0;
    tick(3);
    check("sense_loss_early", 32'(relay), 32'(1));
    tick(1);
    check("sense_loss_drop", 32'(relay), 32'(0));
    check("sense_loss_code", 32'(code), 32'(3));
    do_clear();

    // Table: mode / AS / button combinations, sense held low
    for (int v = 0; v < 6; v++) begin
      mode = vecs[v].m;
      as_close = vecs[v].as_c;
      sense = 1'b0;
      tick(6);
      if (vecs[v].ext) btn_e = 1'b1;
      else             btn_c = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick(1);
        if (relay === 1'b1) seen = 1'b1;
        if (i == 7) begin
          btn_c = 1'b0;
          btn_e = 1'b0;
        end
      end
      check($sformatf("vec%0d_close", v), 32'(seen), 32'(vecs[v].exp_close));
      check($sformatf("vec%0d_code", v), 32'(code), vecs[v].exp_close ? 32'(2) : 32'(0));
      check($sformatf("vec%0d_mask", v), 32'(mask), 32'(0));
      if (vecs[v].exp_close || code != 3'd0) do_clear();
      else tick(6);
    end

    // Autonomous close, then AS request drop
    close_loop(1'b1);
    as_close = 1'b0;
    tick(3);
    check("as_drop_early", 32'(relay), 32'(1));
    tick(1);
    check("as_drop_relay", 32'(relay), 32'(0));
    check("as_drop_code", 32'(code), 32'(4));
    check("as_drop_mask", 32'(mask), 32'(0));
    do_clear();

    // Mode change while closed in manual mode is ignored
    close_loop(1'b0);
    mode = 1'b1;
    as_close = 1'b0;
    tick(10);
    check("mode_change_relay", 32'(relay), 32'(1));
    check("mode_change_code", 32'(code), 32'(0));
    sense = 1'b0;
    tick(6);
    check("ext_open_code", 32'(code), 32'(3));
    do_clear();

    // Close timeout: relay high for exactly CLOSE_TIMEOUT cycles
    mode = 1'b0;
    as_close = 1'b0;
    sense = 1'b0;
    tick(6);
    btn_c = 1'b1;
    wait_relay(1'b1, 30, n);
    check("timeout_relay_up", 32'(n >= 0), 32'(1));
    btn_c = 1'b0;
    cnt = 0;
    while (relay === 1'b1 && cnt < 30) begin
      cnt++;
      tick(1);
    end
    check("timeout_high_cycles", 32'(cnt), 32'(CT));
    check("timeout_code", 32'(code), 32'(2));
    check("timeout_mask", 32'(mask), 32'(0));
    do_clear();

    // Watchdog channel 1 stops while closed
    close_loop(1'b0);
    period[1] = 0;
    l = last_tog[1];
    wait_relay(1'b0, 40, n);
    drop = cyc;
    check("wd_trip_seen", 32'(n >= 0), 32'(1));
    lat = drop - (l + 1);
    check("wd_trip_latency", 32'(lat > WT && lat <= WT + 4), 32'(1));
    check("wd_trip_code", 32'(code), 32'(1));
    check("wd_trip_mask", 32'(mask), 32'(2'b10));
    fclr = 1'b1;
    tick(10);
    check("clear_blocked_code", 32'(code), 32'(1));
    check("clear_blocked_relay", 32'(relay), 32'(0));
    check("clear_blocked_ready", 32'(ready), 32'(0));
    fclr = 1'b0;
    restart_wd(1);
    tick(10);
    check("held_without_clear", 32'(code), 32'(1));
    do_clear();

    // Watchdog expiry and sense drop reach the FSM on the same edge
    close_loop(1'b0);
    period[1] = 0;
    l = last_tog[1];
    while (cyc < l + 17) tick(1);
    sense = 1'b0;
    tick(8);
    check("simul_code", 32'(code), 32'(1));
    check("simul_mask", 32'(mask), 32'(2'b10));
    check("simul_relay", 32'(relay), 32'(0));
    restart_wd(1);
    tick(4);
    do_clear();

    // Reset pulse while closed, cockpit held through reset
    close_loop(1'b0);
    btn_c = 1'b1;
    #2;
    rst_n = 1'b0;
    sense = 1'b0;
    #1;
    check("async_rst_relay", 32'(relay), 32'(0));
    check("async_rst_ready", 32'(ready), 32'(0));
    check("async_rst_code", 32'(code), 32'(0));
    check("async_rst_mask", 32'(mask), 32'(0));
    tick(3);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (relay === 1'b1) seen = 1'b1;
    end
    check("held_btn_no_close", 32'(seen), 32'(0));
    btn_c = 1'b0;
    tick(6);
    check("post_rst_ready", 32'(ready), 32'(1));
    btn_c = 1'b1;
    wait_relay(1'b1, 20, n);
    check("repress_closes", 32'(n >= 0), 32'(1));
    btn_c = 1'b0;
    tick(12);
    check("repress_timeout_code", 32'(code), 32'(2));
    do_clear();

    // Random heartbeat periods: a gap longer than WD_TIMEOUT cycles must trip
    for (int t = 0; t < 10; t++) begin
      c = int'($urandom_range(0, N_WD - 1));
      p = (t == 0) ? WT : (t == 1) ? WT + 1 : int'($urandom_range(3, 24));
      m = 1'($urandom_range(0, 1));
      close_loop(m);
      l = last_tog[c];
      period[c] = p;
      next_tog[c] = l + p;
      exp_trip = (p > WT);
      drop = -1;
      for (int i = 0; i < 60; i++) begin
        tick(1);
        if (relay === 1'b0 && drop < 0) drop = cyc;
      end
      check($sformatf("rnd%0d_p%0d_trip", t, p), 32'(drop >= 0), 32'(exp_trip));
      if (exp_trip) begin
        lat = drop - (l + 1);
        check($sformatf("rnd%0d_latency", t), 32'(lat > WT && lat <= WT + 4), 32'(1));
        check($sformatf("rnd%0d_code", t), 32'(code), 32'(1));
        check($sformatf("rnd%0d_mask", t), 32'(mask), 32'(1 << c));
      end else begin
        check($sformatf("rnd%0d_code", t), 32'(code), 32'(0));
        sense = 1'b0;
        tick(6);
        check($sformatf("rnd%0d_open_code", t), 32'(code), 32'(3));
      end
      restart_wd(c);
      tick(4);
      do_clear();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
